branch_redirect_ctrl: RTL

- Consumer of the EX-stage branch decision (switch_branch) in the RISC-V core.
- Turns a taken branch into a registered PC redirect toward the fetch stage.
- Squashes wrong-path instructions by flushing the IF/ID and ID/EX pipeline registers.
- Holds a pending redirect while fetch is stalled.

---
 rtl/branch_redirect_ctrl_pkg.sv | 16 +
 rtl/branch_redirect_ctrl_redirect_flush_counter.sv | 27 ++
 rtl/branch_redirect_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and default constants for the branch redirect controller.
// Imported by branch_redirect_ctrl and redirect_flush_counter.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brc_state_t;

    localparam int ADDR_W_DEF       = 64;
    localparam int FLUSH_CYCLES_DEF = 2;
    // FLUSH_CYCLES tops out at 15, so the tail count fits in 4 bits.
    localparam int FLUSH_CNT_W      = 4;

endpackage

// File: rtl/branch_redirect_ctrl_redirect_flush_counter.sv
// Loadable down-counter with zero flag; times the flush tail after a redirect.
module redirect_flush_counter
    import branch_redirect_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [FLUSH_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [FLUSH_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Registered PC redirect and pipeline flush sequencing for taken EX branches.
// Optional activity counters are built when BRANCH_REDIRECT_STATS_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a taken branch from EX
// REDIRECT | pc_sel high, both flushes high; held while fetch is stalled
// FLUSH    | flush_if_id tail, FLUSH_CYCLES-1 cycles
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              switch_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              if_stall,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              misalign_err
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]       taken_count,
    output logic [31:0]       stall_count,
    output logic [31:0]       squash_count
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] TAIL_LOAD =
        (FLUSH_CYCLES > 1) ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;

    brc_state_t        state;
    logic [ADDR_W-1:0] target_q;
    logic              branch_req;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    assign branch_req = ex_valid && switch_branch;
    assign cnt_load   = (state == REDIRECT) && !if_stall;
    assign cnt_dec    = (state == FLUSH) && !cnt_zero;
    assign pc_target  = target_q;

    redirect_flush_counter u_flush_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (TAIL_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            target_q     <= '0;
            misalign_err <= 1'b0;
            pc_sel       <= 1'b0;
            flush_if_id  <= 1'b0;
            flush_id_ex  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (branch_req) begin
                        state        <= REDIRECT;
                        target_q     <= branch_target;
                        misalign_err <= (branch_target[1:0] != 2'b00);
                        pc_sel       <= 1'b1;
                        flush_if_id  <= 1'b1;
                        flush_id_ex  <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!if_stall) begin
                        pc_sel      <= 1'b0;
                        flush_id_ex <= 1'b0;
                        if (FLUSH_CYCLES == 1) begin
                            state       <= IDLE;
                            flush_if_id <= 1'b0;
                        end else begin
                            state       <= FLUSH;
                            flush_if_id <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_zero) begin
                        state       <= IDLE;
                        flush_if_id <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pc_sel      <= 1'b0;
                    flush_if_id <= 1'b0;
                    flush_id_ex <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_count  <= '0;
            stall_count  <= '0;
            squash_count <= '0;
        end else begin
            if ((state == IDLE) && branch_req) begin
                taken_count <= taken_count + 32'd1;
            end
            if ((state == REDIRECT) && if_stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if ((state != IDLE) && branch_req) begin
                squash_count <= squash_count + 32'd1;
            end
        end
    end
`endif

endmodule
